// File: rtl/tx_sched_pkg.sv
// Shared constants for the serializer frame scheduler: frame kinds, default
// filler/sync patterns and the serializer frame period.
package tx_sched_pkg;

   localparam int FRAME_LEN = 32;

   typedef enum logic [1:0] {
      KIND_IDLE = 2'd0,
      KIND_DATA = 2'd1,
      KIND_SYNC = 2'd2
   } frame_kind_e;

   localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hBC5A_A5BC;
   localparam logic [31:0] DEFAULT_IDLE_WORD = 32'h7C7C_7C7C;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: the lowest valid index at or above rr_ptr
// wins, otherwise the lowest valid index overall.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [2:0]         rr_ptr,
   output logic               any_valid,
   output logic [NUM_REQ-1:0] grant,
   output logic [2:0]         grant_idx
);

   logic [NUM_REQ-1:0] masked;

   always_comb begin
      masked    = '0;
      grant     = '0;
      grant_idx = '0;
      any_valid = |req_valid;
      for (int i = 0; i < NUM_REQ; i++) begin
         masked[i] = req_valid[i] && (i >= int'(rr_ptr));
      end
      // Descending scans so the lowest index is the last one written.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) grant_idx = 3'(i);
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (masked[i]) grant_idx = 3'(i);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = any_valid && (grant_idx == 3'(i));
      end
   end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Picks one 32-bit frame per serializer period (DATA round-robin, periodic
// SYNC, or IDLE) and holds it stable across the serializer capture cycle.
module tx_frame_scheduler
   import tx_sched_pkg::*;
#(
   parameter int          NUM_REQ     = 4,
   parameter int          SYNC_PERIOD = 256,
   parameter logic [31:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
   parameter logic [31:0] IDLE_WORD   = DEFAULT_IDLE_WORD
) (
   input  logic                  clk1280,
   input  logic                  rst,
   input  logic                  phase_align,
   input  logic                  sync_en,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*32-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [31:0]           frame_out,
   output logic                  frame_sof,
   output logic [1:0]            frame_kind,
   output logic [2:0]            grant_id,
   output logic [15:0]           frame_cnt
);

   localparam int               PH_W      = $clog2(FRAME_LEN);
   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(FRAME_LEN - 1);
   localparam logic [PH_W-1:0]  PH_DEC    = PH_W'(FRAME_LEN - 2);
   localparam int               SC_W      = (SYNC_PERIOD > 2) ? $clog2(SYNC_PERIOD) : 1;
   localparam logic [SC_W-1:0]  SYNC_LAST = SC_W'((SYNC_PERIOD > 0) ? SYNC_PERIOD - 1 : 0);
   localparam bit               SYNC_ON   = (SYNC_PERIOD != 0);

   logic [PH_W-1:0]    phase_q, phase_d;
   logic [2:0]         rr_ptr_q, rr_ptr_d;
   logic [SC_W-1:0]    sync_cnt_q, sync_cnt_d;
   logic [31:0]        frame_q, frame_d;
   frame_kind_e        kind_q, kind_d;
   logic [2:0]         grant_id_q, grant_id_d;
   logic               sof_q, sof_d;
   logic [NUM_REQ-1:0] ready_q, ready_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;

   logic               any_valid;
   logic [NUM_REQ-1:0] arb_grant;
   logic [2:0]         grant_idx;
   logic [31:0]        sel_data;
   logic               decide;
   logic               sync_due;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .any_valid (any_valid),
      .grant     (arb_grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == 3'(i)) sel_data = req_data[32*i +: 32];
      end
   end

   always_comb begin
      phase_d     = (phase_align || phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      rr_ptr_d    = rr_ptr_q;
      sync_cnt_d  = sync_cnt_q;
      frame_d     = frame_q;
      kind_d      = kind_q;
      grant_id_d  = grant_id_q;
      sof_d       = 1'b0;
      ready_d     = '0;
      frame_cnt_d = frame_cnt_q;

      // A phase_align landing on the decision cycle cancels the whole slot.
      decide   = (phase_q == PH_DEC) && !phase_align;
      sync_due = sync_en && SYNC_ON && (sync_cnt_q == SYNC_LAST);

      if (decide) begin
         sof_d       = 1'b1;
         frame_cnt_d = frame_cnt_q + 16'd1;
         if (!sync_en || sync_due) sync_cnt_d = '0;
         else                      sync_cnt_d = sync_cnt_q + SC_W'(1);

         if (sync_due) begin
            frame_d = SYNC_WORD;
            kind_d  = KIND_SYNC;
         end else if (any_valid) begin
            frame_d    = sel_data;
            kind_d     = KIND_DATA;
            grant_id_d = grant_idx;
            ready_d    = arb_grant;
            rr_ptr_d   = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
         end else begin
            frame_d = IDLE_WORD;
            kind_d  = KIND_IDLE;
         end
      end
   end

   always_ff @(posedge clk1280 or posedge rst) begin
      if (rst) begin
         phase_q     <= '0;
         rr_ptr_q    <= '0;
         sync_cnt_q  <= '0;
         frame_q     <= IDLE_WORD;
         kind_q      <= KIND_IDLE;
         grant_id_q  <= '0;
         sof_q       <= 1'b0;
         ready_q     <= '0;
         frame_cnt_q <= '0;
      end else begin
         phase_q     <= phase_d;
         rr_ptr_q    <= rr_ptr_d;
         sync_cnt_q  <= sync_cnt_d;
         frame_q     <= frame_d;
         kind_q      <= kind_d;
         grant_id_q  <= grant_id_d;
         sof_q       <= sof_d;
         ready_q     <= ready_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign req_ready  = ready_q;
   assign frame_out  = frame_q;
   assign frame_sof  = sof_q;
   assign frame_kind = kind_q;
   assign grant_id   = grant_id_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with hand-computed slot expectations.
module tb_tx_frame_scheduler;

   localparam int          NREQ = 4;
   localparam logic [31:0] IDLE = 32'h7C7C_7C7C;
   localparam logic [31:0] SYNC = 32'hBC5A_A5BC;

   logic               clk1280;
   logic               rst;
   logic               phase_align;
   logic               sync_en;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*32-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic [31:0]        frame_out;
   logic               frame_sof;
   logic [1:0]         frame_kind;
   logic [2:0]         grant_id;
   logic [15:0]        frame_cnt;

   int          n_chk;
   int          n_bad;
   int          exp_cnt;
   logic [31:0] dv [NREQ];

   tx_frame_scheduler #(.NUM_REQ(NREQ), .SYNC_PERIOD(4)) dut (
      .clk1280     (clk1280),
      .rst         (rst),
      .phase_align (phase_align),
      .sync_en     (sync_en),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .frame_out   (frame_out),
      .frame_sof   (frame_sof),
      .frame_kind  (frame_kind),
      .grant_id    (grant_id),
      .frame_cnt   (frame_cnt)
   );

   initial clk1280 = 1'b0;
   always #5 clk1280 = ~clk1280;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk1280);
      #1;
   endtask

   task automatic run_to_sof(output int n);
      n = 0;
      while (n <= 40) begin
         tick();
         n++;
         if (frame_sof) return;
      end
   endtask

   // Runs to the next sof (31 cycles from phase 0), checks the new frame,
   // then one more cycle to see the pulses drop and the frame hold.
   task automatic slot(input string tag, input logic [31:0] ef, input logic [1:0] ek,
                       input logic [2:0] eg, input logic [3:0] er);
      int n;
      run_to_sof(n);
      exp_cnt++;
      chk({tag, "_gap"}, n, 31);
      chk({tag, "_frame"}, frame_out, ef);
      chk({tag, "_kind"}, {30'd0, frame_kind}, {30'd0, ek});
      chk({tag, "_gid"}, {29'd0, grant_id}, {29'd0, eg});
      chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, er});
      chk({tag, "_cnt"}, {16'd0, frame_cnt}, exp_cnt);
      tick();
      chk({tag, "_sof_drop"}, {31'd0, frame_sof}, 0);
      chk({tag, "_ready_drop"}, {28'd0, req_ready}, 0);
      chk({tag, "_hold"}, frame_out, ef);
   endtask

   initial begin
      n_chk = 0; n_bad = 0; exp_cnt = 0;
      dv[0] = 32'hD0D0_0000; dv[1] = 32'hD1D1_1111;
      dv[2] = 32'hD2D2_2222; dv[3] = 32'hD3D3_3333;
      req_data = {dv[3], dv[2], dv[1], dv[0]};
      rst = 1'b1; phase_align = 1'b0; sync_en = 1'b0; req_valid = '0;
      tick(); tick();
      chk("rst_frame", frame_out, IDLE);
      chk("rst_kind", {30'd0, frame_kind}, 0);
      chk("rst_gid", {29'd0, grant_id}, 0);
      chk("rst_sof", {31'd0, frame_sof}, 0);
      chk("rst_ready", {28'd0, req_ready}, 0);
      chk("rst_cnt", {16'd0, frame_cnt}, 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) slot("idle", IDLE, 2'd0, 3'd0, 4'b0000);

      req_valid = 4'b1111;
      slot("rr0", dv[0], 2'd1, 3'd0, 4'b0001);
      slot("rr1", dv[1], 2'd1, 3'd1, 4'b0010);
      slot("rr2", dv[2], 2'd1, 3'd2, 4'b0100);
      slot("rr3", dv[3], 2'd1, 3'd3, 4'b1000);
      slot("rr4", dv[0], 2'd1, 3'd0, 4'b0001);

      req_valid = 4'b0010;
      slot("ptr2", dv[1], 2'd1, 3'd1, 4'b0010);
      req_valid = 4'b1010;
      slot("sp3", dv[3], 2'd1, 3'd3, 4'b1000);
      slot("sp1", dv[1], 2'd1, 3'd1, 4'b0010);

      req_valid = 4'b0001;
      sync_en = 1'b1;
      slot("sy0", dv[0], 2'd1, 3'd0, 4'b0001);
      slot("sy1", dv[0], 2'd1, 3'd0, 4'b0001);
      slot("sy2", dv[0], 2'd1, 3'd0, 4'b0001);
      slot("sy3", SYNC, 2'd2, 3'd0, 4'b0000);
      slot("sy4", dv[0], 2'd1, 3'd0, 4'b0001);
      sync_en = 1'b0;

      for (int i = 0; i < 30; i++) tick();
      phase_align = 1'b1;
      tick();
      phase_align = 1'b0;
      chk("pa_sof", {31'd0, frame_sof}, 0);
      chk("pa_ready", {28'd0, req_ready}, 0);
      chk("pa_hold", frame_out, dv[0]);
      chk("pa_cnt", {16'd0, frame_cnt}, exp_cnt);
      slot("pa_next", dv[0], 2'd1, 3'd0, 4'b0001);

      for (int i = 0; i < 15; i++) tick();
      rst = 1'b1;
      #1;
      chk("mr_frame", frame_out, IDLE);
      chk("mr_kind", {30'd0, frame_kind}, 0);
      chk("mr_cnt", {16'd0, frame_cnt}, 0);
      req_valid = 4'b1111;
      tick();
      rst = 1'b0;
      exp_cnt = 0;
      slot("mr_first", dv[0], 2'd1, 3'd0, 4'b0001);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
Feeds the 32-bit frame input of the 1.28 GHz MSB-first bit serializer. The serializer takes one frame every 32 clk1280 cycles. At each frame slot this block picks the next frame from NUM_REQ requesters (round-robin, valid/ready), a periodic SYNC word, or an IDLE word. It holds the chosen frame stable across the serializer's capture cycle. It sits between the channel framers and the serializer, on clk1280.

Parameters:
NUM_REQ, 4, number of requesting channels (2..8)
FRAME_LEN, 32, bits per frame = serializer period in cycles
SYNC_PERIOD, 256, frames between forced SYNC frames (>=2); 0 disables
SYNC_WORD, 32'hBC5A_A5BC, sync frame pattern
IDLE_WORD, 32'h7C7C_7C7C, filler frame when no requester is valid

Ports:
clk1280  in  1  serial-rate clock
rst  in  1  reset; asynchronous, active-high
phase_align  in  1  synchronous; forces phase counter to 0 on the next edge
sync_en  in  1  enables periodic SYNC insertion
req_valid  in  NUM_REQ  per-channel frame available
req_data  in  NUM_REQ*32  channel i frame at [32*i+31:32*i]
req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse
frame_out  out  32  frame to serializer
frame_sof  out  1  1-cycle pulse when frame_out updates
frame_kind  out  2  0=IDLE, 1=DATA, 2=SYNC
grant_id  out  3  channel index of the current DATA frame
frame_cnt  out  16  frames issued, wraps at 2^16

Behaviour:
- Reset (async assert, sync release) gives: phase=0, rr_ptr=0, sync_cnt=0, frame_out=IDLE_WORD, frame_kind=0, grant_id=0, frame_sof=0, req_ready=0, frame_cnt=0.
- phase: 5-bit counter, 0..FRAME_LEN-1, wraps to 0. phase_align overrides the increment and loads 0. The serializer captures at phase==31, so phase 0 must match the serializer's counter 0 after phase_align.
- Decision cycle is phase==FRAME_LEN-2 (30). Priority at that cycle:
  1. SYNC if sync_en=1, SYNC_PERIOD!=0 and sync_cnt==SYNC_PERIOD-1.
  2. Otherwise, the first valid requester searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  3. Otherwise, IDLE.
- Registered at the edge ending phase 30:
  - frame_out, frame_kind and grant_id (grant_id holds its old value on SYNC or IDLE).
  - frame_sof=1 for exactly that one following cycle (phase 31).
  - req_ready[winner]=1 for that same cycle. The requester may drop or change data after this edge.
  - frame_cnt+=1.
- frame_out stays constant from phase 31 through the next phase 30, so it is stable at capture. Latency from the decision to the first serialized bit is 2 cycles.
- rr_ptr becomes winner+1 (mod NUM_REQ) after a DATA grant. It is unchanged on SYNC or IDLE.
- sync_cnt increments every frame slot and clears when SYNC is sent. While sync_en=0 it clears and no SYNC is sent. A SYNC that falls due while requesters are waiting delays them by one slot; nothing is dropped.
- req_valid is sampled only at phase 30. A requester must hold valid and data until it sees ready. Deasserting valid before the grant withdraws the request.
- phase_align asserted at phase 30 suppresses that decision: no grant, no sof, and frame_out is held.
- Reset mid-frame: outputs snap to reset values immediately. Any pending request is not granted.
- Counter wrap: frame_cnt wraps 0xFFFF to 0. rr_ptr wraps NUM_REQ-1 to 0.

Decomposition:
- Shared package tx_sched_pkg holds:
  - frame_kind encodings KIND_IDLE, KIND_DATA, KIND_SYNC;
  - default SYNC_WORD and IDLE_WORD;
  - FRAME_LEN.
- One sub-module, rr_arbiter: combinational masked round-robin select from req_valid and rr_ptr, giving a one-hot grant plus index.
- Phase and sync counters, and the output registers, stay in the top level.

Test Plan:
- Reset, no requests, sync_en=0, run 4 frames -> frame_out=0x7C7C7C7C, frame_kind=0, frame_sof high only at phase 31, frame_cnt=4.
- req_valid=4'b1111 held with distinct data D0..D3 -> grants 0,1,2,3,0 in consecutive slots. req_ready pulses only at phase 31, and frame_out equals the granted channel's data.
- req_valid=4'b1010, rr_ptr=2 -> ch3 is granted, then ch1. Idle channels are never granted.
- SYNC_PERIOD=4, sync_en=1, ch0 always valid -> slots 0-2 are DATA, slot 3 is 0xBC5AA5BC with req_ready=0 that slot. ch0 resumes in slot 4.
- phase_align pulsed at phase 30 -> no sof or grant that slot, phase restarts at 0, and the next decision comes 31 cycles later.
- rst asserted at phase 15 mid-DATA frame -> frame_out=IDLE_WORD immediately. After release the first sof is at phase 31 and rr_ptr=0.
